// File: rtl/ca6_range_reducer.sv
// Argument conditioning ahead of the Ca6 cosine core: reduces an unsigned
// Q4.12 angle modulo 2*pi, then folds it into [0, pi/2] with a negate flag.
module ca6_range_reducer #(
   parameter int W       = 16,
   parameter int TWO_PI  = 25736,
   parameter int PI      = 12868,
   parameter int HALF_PI = 6434
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] xin,
   input  logic [7:0]   yin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] xr,
   output logic [7:0]   yout,
   output logic         neg
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] REDUCE    = 3'd1;
   localparam logic [2:0] FOLD_PI   = 3'd2;
   localparam logic [2:0] FOLD_HALF = 3'd3;
   localparam logic [2:0] DONE      = 3'd4;

   localparam logic [W-1:0] TWO_PI_W  = W'(TWO_PI);
   localparam logic [W-1:0] PI_W      = W'(PI);
   localparam logic [W-1:0] HALF_PI_W = W'(HALF_PI);

   logic [2:0]   state;
   logic [W-1:0] acc;
   logic         ncur;
   logic [7:0]   ybuf;

   // Every subtraction sits under the comparison that guarantees no underflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         acc   <= '0;
         ncur  <= 1'b0;
         ybuf  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc   <= xin;
                  ybuf  <= yin;
                  ncur  <= 1'b0;
                  state <= REDUCE;
               end
            end
            REDUCE: begin
               if (acc >= TWO_PI_W) begin
                  acc <= acc - TWO_PI_W;
               end else begin
                  state <= FOLD_PI;
               end
            end
            FOLD_PI: begin
               if (acc >= PI_W) begin
                  acc  <= acc - PI_W;
                  ncur <= 1'b1;
               end
               state <= FOLD_HALF;
            end
            FOLD_HALF: begin
               if (acc > HALF_PI_W) begin
                  acc  <= PI_W - acc;
                  ncur <= ~ncur;
               end
               state <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs come straight from registers, so they hold while stalled in DONE.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign xr        = acc;
   assign neg       = ncur;
   assign yout      = ybuf;

endmodule

// File: tb/tb_ca6_range_reducer.sv
// Self-checking bench for ca6_range_reducer: directed boundary jobs plus
// randomized jobs compared against a modulo-arithmetic reference.
module tb_ca6_range_reducer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] xin;
   logic [7:0]  yin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] xr;
   logic [7:0]  yout;
   logic        neg;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   ca6_range_reducer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .xin       (xin),
      .yin       (yin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .xr        (xr),
      .yout      (yout),
      .neg       (neg)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // cos(x) = (n ? -1 : 1) * cos(r), r in [0, pi/2]
   function automatic void refModel(input int x, output int r, output bit n, output int lat);
      r = x % 25736;
      n = 1'b0;
      if (r >= 12868) begin
         r = r - 12868;
         n = 1'b1;
      end
      if (r > 6434) begin
         r = 12868 - r;
         n = ~n;
      end
      lat = x / 25736 + 3;
   endfunction

   // garbage=1 keeps in_valid high with junk data while the block is busy.
   task automatic applyStimulus(input int x, input int y, input int stall, input bit garbage);
      int  expR;
      bit  expN;
      int  expLat;
      int  lat;
      refModel(x, expR, expN, expLat);
      checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
      xin      = 16'(x);
      yin      = 8'(y);
      in_valid = 1'b1;
      tick();
      if (garbage) begin
         xin = 16'($urandom);
         yin = 8'($urandom);
      end else begin
         in_valid = 1'b0;
      end
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
         if (garbage) xin = 16'($urandom);
      end
      checkOutput("latency", 32'(lat), 32'(expLat));
      checkOutput("xr", 32'(xr), 32'(expR));
      checkOutput("neg", 32'(neg), 32'(expN));
      checkOutput("yout", 32'(yout), 32'(y & 8'hff));
      checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
      for (int i = 0; i < stall; i++) begin
         out_ready = 1'b0;
         tick();
         if (garbage) xin = 16'($urandom);
         checkOutput("stall_valid", 32'(out_valid), 32'd1);
         checkOutput("stall_xr", 32'(xr), 32'(expR));
         checkOutput("stall_neg", 32'(neg), 32'(expN));
         checkOutput("stall_yout", 32'(yout), 32'(y & 8'hff));
         checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("drain_valid", 32'(out_valid), 32'd0);
      checkOutput("drain_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      xin       = '0;
      yin       = '0;

      // Reset held for two cycles.
      tick();
      tick();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_xr", 32'(xr), 32'd0);
      checkOutput("rst_neg", 32'(neg), 32'd0);
      checkOutput("rst_yout", 32'(yout), 32'd0);
      rst = 1'b1;

      // Reset in the middle of REDUCE discards the job.
      xin      = 16'd65535;
      yin      = 8'hA5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_xr", 32'(xr), 32'd0);
      checkOutput("midrst_yout", 32'(yout), 32'd0);
      for (int i = 0; i < 8; i++) begin
         checkOutput("midrst_no_valid", 32'(out_valid), 32'd0);
         tick();
      end

      // Directed jobs: small angle, double fold, max, boundaries.
      applyStimulus(67, 1, 0, 1'b0);
      applyStimulus(20000, 2, 0, 1'b0);
      applyStimulus(65535, 3, 0, 1'b0);
      applyStimulus(6434, 4, 0, 1'b0);
      applyStimulus(6435, 5, 0, 1'b0);
      applyStimulus(12868, 6, 0, 1'b0);
      applyStimulus(12867, 7, 0, 1'b0);
      applyStimulus(25736, 8, 0, 1'b0);
      applyStimulus(25735, 9, 0, 1'b0);
      applyStimulus(51472, 10, 0, 1'b0);
      applyStimulus(0, 11, 0, 1'b0);

      // Backpressure for 10 cycles, then back-to-back jobs.
      applyStimulus(20000, 8'h5A, 10, 1'b1);
      applyStimulus(67, 12, 0, 1'b0);
      applyStimulus(20000, 13, 0, 1'b0);

      // Reset while a result waits in DONE: it is never delivered.
      xin      = 16'd67;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checkOutput("done_valid", 32'(out_valid), 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkOutput("donerst_valid", 32'(out_valid), 32'd0);
      checkOutput("donerst_in_ready", 32'(in_ready), 32'd1);

      // Randomized jobs.
      for (int j = 0; j < 40; j++) begin
         applyStimulus(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
